game_state_engine: RTL

//  Parametrised game controller: owns the run/pause/end state machine, player vertical motion and obstacle collision.

---
 rtl/game_state_engine.sv | 120 ++++++++++++
 1 files changed

// File: rtl/game_state_engine.sv
// game_state_engine: run/pause/end FSM with player vertical motion and obstacle collision
// ports: clk, rst (sync, active-high); btn[2:0] debounced levels {end/new, start/pause, flip};
//   frame_tick one-cycle frame pulse; obstacle_x/obstacle_y packed {right,left}/{bottom,top} per slot;
//   gamemode 00 INIT/01 RUN/10 PAUSE/11 END; player_y top edge; gravity_dir 1 = up;
//   score ticks survived (saturating); collision one-cycle pulse on the hit that ends a game
module game_state_engine #(
  parameter int N_OBS    = 10,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int PLAYER_X = 160,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 464,
  parameter int Y_INIT   = 240,
  parameter int SPEED    = 4,
  parameter int SCORE_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               btn,
  input  logic                     frame_tick,
  input  logic [N_OBS*2*X_W-1:0]   obstacle_x,
  input  logic [N_OBS*2*Y_W-1:0]   obstacle_y,
  output logic [1:0]               gamemode,
  output logic [Y_W-1:0]           player_y,
  output logic                     gravity_dir,
  output logic [SCORE_W-1:0]       score,
  output logic                     collision
);
  typedef enum logic [1:0] {INIT = 2'b00, RUN = 2'b01, PAUSE = 2'b10, GAME_END = 2'b11} mode_t;
  mode_t mode, mode_n;
  logic [2:0] btn_q, press;
  logic [N_OBS-1:0] hit_v;
  logic hit;
  logic [Y_W:0] y_sum;
  logic [Y_W-1:0] y_move, y_n;
  logic [SCORE_W-1:0] score_n;
  logic dir_n, col_n;
  assign press = btn & ~btn_q;
  genvar i;
  generate
    for (i = 0; i < N_OBS; i++) begin : g_slot
      logic [X_W-1:0] xl, xr;
      logic [Y_W-1:0] yt, yb;
      assign xl = obstacle_x[i*2*X_W +: X_W];
      assign xr = obstacle_x[i*2*X_W+X_W +: X_W];
      assign yt = obstacle_y[i*2*Y_W +: Y_W];
      assign yb = obstacle_y[i*2*Y_W+Y_W +: Y_W];
      // widened compares so the right/bottom player edges cannot wrap
      assign hit_v[i] = (xr > xl) &&
                        ((X_W+1)'(PLAYER_X) < {1'b0, xr}) &&
                        ((X_W+1)'(PLAYER_X + PLAYER_W) > {1'b0, xl}) &&
                        (player_y < yb) &&
                        (({1'b0, player_y} + (Y_W+1)'(PLAYER_H)) > {1'b0, yt});
    end
  endgenerate
  assign hit = |hit_v;
  assign y_sum = {1'b0, player_y} + (Y_W+1)'(SPEED);
  assign y_move = gravity_dir
    ? (({1'b0, player_y} < (Y_W+1)'(Y_MIN + SPEED)) ? Y_W'(Y_MIN) : player_y - Y_W'(SPEED))
    : ((y_sum > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : y_sum[Y_W-1:0]);
  always_comb begin
    mode_n = mode;
    y_n = player_y;
    dir_n = gravity_dir;
    score_n = score;
    col_n = 1'b0;
    case (mode)
      INIT: begin
        if (press[2]) begin
          y_n = Y_W'(Y_INIT);
          dir_n = 1'b0;
          score_n = '0;
        end else if (press[1]) mode_n = RUN;
      end
      RUN: begin
        if (press[2]) mode_n = GAME_END;
        else if (press[1]) mode_n = PAUSE;
        else if (frame_tick && hit) begin
          mode_n = GAME_END;
          col_n = 1'b1;
        end else begin
          if (frame_tick) begin
            y_n = y_move;
            score_n = &score ? score : score + 1'b1;
          end
          if (press[0]) dir_n = ~gravity_dir;
        end
      end
      PAUSE: mode_n = press[2] ? GAME_END : press[1] ? RUN : PAUSE;
      default: begin
        if (press[2]) begin
          mode_n = INIT;
          y_n = Y_W'(Y_INIT);
          dir_n = 1'b0;
          score_n = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= INIT;
      player_y <= Y_W'(Y_INIT);
      gravity_dir <= 1'b0;
      score <= '0;
      collision <= 1'b0;
      btn_q <= 3'b111;
    end else begin
      mode <= mode_n;
      player_y <= y_n;
      gravity_dir <= dir_n;
      score <= score_n;
      collision <= col_n;
      btn_q <= btn;
    end
  end
  assign gamemode = mode;
endmodule
